// File: rtl/csr_wb_issuer_pkg.sv
// Shared definitions for the CSR writeback issuer: op encodings, CSR addresses,
// FSM states and small decode helpers.
package csr_wb_issuer_pkg;

  typedef enum logic [2:0] {
    OP_RW    = 3'd0,
    OP_RS    = 3'd1,
    OP_RC    = 3'd2,
    OP_ECALL = 3'd3,
    OP_MRET  = 3'd4
  } csr_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  localparam logic [31:0] MCAUSE_ECALL  = 32'h0000_000B;

  // Ops that read-modify-write a CSR and return the old value to rd.
  function automatic logic is_rmw(input logic [2:0] op);
    return (op == OP_RW) || (op == OP_RS) || (op == OP_RC);
  endfunction

  // Standard CSR map: top two address bits set means read-only.
  function automatic logic is_ro_csr(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_wb_issuer_if.sv
// EXU request, CSR unit request and downstream writeback signals of the issuer.
// master = issuer side, slave = surrounding environment.
interface csr_wb_issuer_if #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12,
  parameter int RF_AW  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [CSR_AW-1:0] in_csr_addr;
  logic [XLEN-1:0]   in_src;
  logic              in_src_zero;
  logic [RF_AW-1:0]  in_rd;
  logic [XLEN-1:0]   in_pc;

  logic [CSR_AW-1:0] csr_raddr;
  logic [XLEN-1:0]   csr_rdata;
  logic              csr_valid;
  logic              csr_ready;
  logic [CSR_AW-1:0] csr_waddr;
  logic [XLEN-1:0]   csr_wdata;
  logic              csr_wen;
  logic              csr_is_ecall;
  logic [XLEN-1:0]   csr_pc;

  logic              out_valid;
  logic              out_ready;
  logic              rd_wen;
  logic [RF_AW-1:0]  rd_addr;
  logic [XLEN-1:0]   rd_wdata;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              illegal;

  modport master (
    input  in_valid, in_op, in_csr_addr, in_src, in_src_zero, in_rd, in_pc,
    output in_ready,
    output csr_raddr, input csr_rdata,
    output csr_valid, input csr_ready,
    output csr_waddr, csr_wdata, csr_wen, csr_is_ecall, csr_pc,
    output out_valid, input out_ready,
    output rd_wen, rd_addr, rd_wdata, redirect_valid, redirect_pc, illegal
  );

  modport slave (
    output in_valid, in_op, in_csr_addr, in_src, in_src_zero, in_rd, in_pc,
    input  in_ready,
    input  csr_raddr, output csr_rdata,
    input  csr_valid, output csr_ready,
    input  csr_waddr, csr_wdata, csr_wen, csr_is_ecall, csr_pc,
    input  out_valid, output out_ready,
    input  rd_wen, rd_addr, rd_wdata, redirect_valid, redirect_pc, illegal
  );
endinterface

// File: rtl/csr_wb_issuer_rmw_alu.sv
// Read-modify-write data and write-enable for CSRRW/CSRRS/CSRRC;
// every other op produces no write.
module csr_rmw_alu
  import csr_wb_issuer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  input  logic            i_src_zero,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_wen
);

  always_comb begin
    o_wdata = '0;
    o_wen   = 1'b0;
    case (i_op)
      OP_RW: begin
        o_wdata = i_src;
        o_wen   = 1'b1;
      end
      // Set/clear with x0 or zimm==0 must not write (CSR side effects).
      OP_RS: begin
        o_wdata = i_old | i_src;
        o_wen   = !i_src_zero;
      end
      OP_RC: begin
        o_wdata = i_old & ~i_src;
        o_wen   = !i_src_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_wb_issuer.sv
// Issues one SYSTEM instruction at a time to the CSR unit and returns rd/redirect.
// Define CSR_WB_RO_CHECK_EN to suppress and flag writes to read-only CSRs.
module csr_wb_issuer
  import csr_wb_issuer_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12,
  parameter int RF_AW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  csr_wb_issuer_if.master  bus
);

  state_e            r_state, w_state_nxt;
  logic [2:0]        r_op;
  logic [CSR_AW-1:0] r_addr;
  logic [RF_AW-1:0]  r_rd;
  logic [XLEN-1:0]   r_pc, r_old, r_wdata;
  logic              r_wen;
  logic              w_accept, w_alu_wen, w_wen;
  logic [XLEN-1:0]   w_alu_wdata;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;

  csr_rmw_alu #(.XLEN(XLEN)) u_alu (
    .i_op      (bus.in_op),
    .i_old     (bus.csr_rdata),
    .i_src     (bus.in_src),
    .i_src_zero(bus.in_src_zero),
    .o_wdata   (w_alu_wdata),
    .o_wen     (w_alu_wen)
  );

`ifdef CSR_WB_RO_CHECK_EN
  logic r_illegal, w_ro_hit;
  assign w_ro_hit = w_alu_wen && is_ro_csr(12'(bus.in_csr_addr));
  assign w_wen    = w_alu_wen && !w_ro_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_illegal <= 1'b0;
    else if (w_accept) r_illegal <= w_ro_hit;
  end
`else
  assign w_wen = w_alu_wen;
`endif

  // Old value is sampled in the accept cycle, so the write lands on fresh data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_addr  <= '0;
      r_rd    <= '0;
      r_pc    <= '0;
      r_old   <= '0;
      r_wdata <= '0;
      r_wen   <= 1'b0;
    end else if (w_accept) begin
      r_op    <= bus.in_op;
      r_addr  <= bus.in_csr_addr;
      r_rd    <= bus.in_rd;
      r_pc    <= bus.in_pc;
      r_old   <= bus.csr_rdata;
      r_wdata <= w_alu_wdata;
      r_wen   <= w_wen;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt        = r_state;
    bus.in_ready       = 1'b0;
    bus.csr_raddr      = '0;
    bus.csr_valid      = 1'b0;
    bus.csr_waddr      = '0;
    bus.csr_wdata      = '0;
    bus.csr_wen        = 1'b0;
    bus.csr_is_ecall   = 1'b0;
    bus.csr_pc         = '0;
    bus.out_valid      = 1'b0;
    bus.rd_wen         = 1'b0;
    bus.rd_addr        = '0;
    bus.rd_wdata       = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.illegal        = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        case (bus.in_op)
          OP_ECALL: bus.csr_raddr = CSR_AW'(CSR_MTVEC);
          OP_MRET:  bus.csr_raddr = CSR_AW'(CSR_MEPC);
          default:  bus.csr_raddr = bus.in_csr_addr;
        endcase
        if (bus.in_valid)
          w_state_nxt = (is_rmw(bus.in_op) || bus.in_op == OP_ECALL) ? S_REQ : S_RESP;
      end
      S_REQ: begin
        bus.csr_valid    = 1'b1;
        bus.csr_waddr    = r_addr;
        bus.csr_wdata    = r_wdata;
        bus.csr_wen      = r_wen;
        bus.csr_is_ecall = (r_op == OP_ECALL);
        bus.csr_pc       = r_pc;
        if (bus.csr_ready) w_state_nxt = S_WAIT;
      end
      // One idle cycle while the CSR unit commits, so the next read sees it.
      S_WAIT: w_state_nxt = S_RESP;
      S_RESP: begin
        bus.out_valid      = 1'b1;
        bus.rd_wen         = is_rmw(r_op) && (r_rd != '0);
        bus.rd_addr        = r_rd;
        bus.rd_wdata       = r_old;
        bus.redirect_valid = (r_op == OP_ECALL) || (r_op == OP_MRET);
        bus.redirect_pc    = r_old;
`ifdef CSR_WB_RO_CHECK_EN
        bus.illegal        = r_illegal;
`endif
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_wb_issuer.sv
// Randomized and directed bench for csr_wb_issuer against a transaction-level
// reference model of the CSR read-modify-write / trap-redirect rules.
module tb_csr_wb_issuer;
  logic clk, rst;
  logic [31:0] csr_mem [4096];
  int n_vec, n_err;

  csr_wb_issuer_if #(.XLEN(32), .CSR_AW(12), .RF_AW(5)) bus ();
  csr_wb_issuer #(.XLEN(32), .CSR_AW(12), .RF_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.csr_rdata = csr_mem[bus.csr_raddr];
  always #5 clk = ~clk;

  // Reference-model expectations
  logic [11:0] e_raddr;
  bit          e_req, e_wen, e_ill, e_rdwen, e_redir;
  logic [31:0] e_wdata, e_old;
  int          e_lat, e_reqcnt;

  // Observations of one transaction
  logic [11:0] o_raddr, o_waddr;
  logic [31:0] o_wdata, o_pc, o_rdwdata, o_redir_pc;
  logic [4:0]  o_rdaddr;
  logic        o_in_ready, o_in_ready_after, o_wen, o_ecall, o_rdwen, o_redir, o_ill;
  int          o_req_cnt, o_lat;
  bit          o_req_unstable, o_resp_unstable, o_timeout;

  function automatic void model(input logic [2:0] op, input logic [11:0] addr,
                                input logic [31:0] src, input logic sz,
                                input logic [4:0] rd, input int rdy_dly);
    e_raddr = (op == 3'd3) ? 12'h305 : (op == 3'd4) ? 12'h341 : addr;
    e_old   = csr_mem[e_raddr];
    e_req   = (op <= 3'd3);
    e_wdata = (op == 3'd0) ? src : (op == 3'd1) ? (e_old | src) : (e_old & ~src);
    e_wen   = (op == 3'd0) ? 1'b1 : (op <= 3'd2) ? !sz : 1'b0;
    e_ill   = 1'b0;
`ifdef CSR_WB_RO_CHECK_EN
    if (e_wen && addr[11:10] == 2'b11) begin
      e_wen = 1'b0;
      e_ill = 1'b1;
    end
`endif
    e_rdwen  = (op <= 3'd2) && (rd != 5'd0);
    e_redir  = (op == 3'd3) || (op == 3'd4);
    e_lat    = e_req ? 3 + rdy_dly : 1;
    e_reqcnt = e_req ? 1 + rdy_dly : 0;
  endfunction

  // Drives one instruction and acts as the CSR unit and downstream stage.
  task automatic run(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                     input logic sz, input logic [4:0] rd, input logic [31:0] pc,
                     input int rdy_dly, input int out_dly);
    int rw;
    bit seen, done;
    logic [77:0] qsnap;
    logic [71:0] rsnap;
    o_req_cnt = 0; o_req_unstable = 0; o_resp_unstable = 0; o_lat = 0; o_timeout = 0;
    seen = 0; done = 0; rw = 0; qsnap = '0; rsnap = '0;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_csr_addr = addr; bus.in_src = src;
    bus.in_src_zero = sz; bus.in_rd = rd; bus.in_pc = pc;
    #1;
    o_raddr = bus.csr_raddr;
    o_in_ready = bus.in_ready;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_op = 3'($urandom); bus.in_csr_addr = 12'($urandom);
    bus.in_src = $urandom; bus.in_src_zero = 1'($urandom); bus.in_rd = 5'($urandom);
    bus.in_pc = $urandom;
    @(negedge clk);
    for (int c = 1; c <= 100 && !done; c++) begin
      bus.csr_ready = 1'b0;
      if (bus.csr_valid) begin
        if (o_req_cnt == 0) begin
          o_waddr = bus.csr_waddr; o_wdata = bus.csr_wdata; o_wen = bus.csr_wen;
          o_ecall = bus.csr_is_ecall; o_pc = bus.csr_pc;
          qsnap = {o_waddr, o_wdata, o_wen, o_ecall, o_pc};
        end else if ({bus.csr_waddr, bus.csr_wdata, bus.csr_wen, bus.csr_is_ecall, bus.csr_pc} !== qsnap)
          o_req_unstable = 1;
        o_req_cnt++;
        bus.csr_ready = (o_req_cnt > rdy_dly);
        if (bus.csr_ready) begin
          if (o_wen && o_waddr[11:10] != 2'b11) csr_mem[o_waddr] = o_wdata;
          if (o_ecall) begin
            csr_mem[12'h341] = o_pc;
            csr_mem[12'h342] = 32'hB;
          end
        end
      end
      if (bus.out_valid) begin
        if (!seen) begin
          seen = 1; o_lat = c;
          o_rdwen = bus.rd_wen; o_rdaddr = bus.rd_addr; o_rdwdata = bus.rd_wdata;
          o_redir = bus.redirect_valid; o_redir_pc = bus.redirect_pc; o_ill = bus.illegal;
          rsnap = {o_rdwen, o_rdaddr, o_rdwdata, o_redir, o_redir_pc, o_ill};
        end else if ({bus.rd_wen, bus.rd_addr, bus.rd_wdata, bus.redirect_valid,
                      bus.redirect_pc, bus.illegal} !== rsnap)
          o_resp_unstable = 1;
        rw++;
        bus.out_ready = (rw > out_dly);
        done = bus.out_ready;
      end
      @(negedge clk);
    end
    o_timeout = !done;
    bus.csr_ready = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    o_in_ready_after = bus.in_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_vec++;
    if ({bus.csr_raddr, bus.csr_valid, bus.csr_waddr, bus.csr_wdata, bus.csr_wen, bus.csr_is_ecall,
         bus.csr_pc, bus.out_valid, bus.rd_wen, bus.rd_addr, bus.rd_wdata, bus.redirect_valid,
         bus.redirect_pc, bus.illegal} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got nonzero output (valid=%b out_valid=%b) want all 0",
                        bus.csr_valid, bus.out_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.csr_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release: in_ready=%b csr_valid=%b out_valid=%b want 1/0/0",
                        bus.in_ready, bus.csr_valid, bus.out_valid);
    end
  endtask

  task automatic test_csrrw();
    csr_mem[12'h305] = 32'h0;
    run(3'd0, 12'h305, 32'h8000_0100, 1'b0, 5'd1, 32'h8000_0000, 0, 0);
    n_vec++; if (o_timeout) begin n_err++; $display("FAIL rw_timeout: got timeout want completion"); end
    n_vec++; if (o_req_cnt !== 1) begin n_err++; $display("FAIL rw_req_cycles: got %0d want 1", o_req_cnt); end
    n_vec++; if (o_wdata !== 32'h8000_0100 || o_wen !== 1'b1) begin n_err++; $display("FAIL rw_write: got %h/%b want 80000100/1", o_wdata, o_wen); end
    n_vec++; if (o_waddr !== 12'h305) begin n_err++; $display("FAIL rw_waddr: got %h want 305", o_waddr); end
    n_vec++; if (o_lat !== 3) begin n_err++; $display("FAIL rw_latency: got %0d want 3", o_lat); end
    n_vec++; if (o_rdwen !== 1'b1 || o_rdwdata !== 32'h0) begin n_err++; $display("FAIL rw_rd: got %b/%h want 1/0", o_rdwen, o_rdwdata); end
  endtask

  task automatic test_csrrs();
    csr_mem[12'h300] = 32'h1800;
    run(3'd1, 12'h300, 32'h8, 1'b0, 5'd5, 32'h8000_0010, 0, 0);
    n_vec++; if (o_wdata !== 32'h1808 || o_wen !== 1'b1) begin n_err++; $display("FAIL rs_write: got %h/%b want 1808/1", o_wdata, o_wen); end
    n_vec++; if (o_rdwen !== 1'b1 || o_rdaddr !== 5'd5 || o_rdwdata !== 32'h1800) begin
      n_err++; $display("FAIL rs_rd: got %b/%0d/%h want 1/5/1800", o_rdwen, o_rdaddr, o_rdwdata); end
    csr_mem[12'h300] = 32'h1800;
    run(3'd1, 12'h300, 32'h0, 1'b1, 5'd5, 32'h8000_0014, 0, 0);
    n_vec++; if (o_req_cnt !== 1 || o_wen !== 1'b0) begin n_err++; $display("FAIL rs_zero: got req=%0d wen=%b want 1/0", o_req_cnt, o_wen); end
    n_vec++; if (o_rdwdata !== 32'h1800 || o_lat !== 3) begin n_err++; $display("FAIL rs_zero_resp: got %h lat %0d want 1800 lat 3", o_rdwdata, o_lat); end
  endtask

  task automatic test_ecall();
    csr_mem[12'h305] = 32'h8000_0200;
    run(3'd3, 12'h123, 32'h0, 1'b1, 5'd3, 32'h8000_0040, 3, 0);
    n_vec++; if (o_raddr !== 12'h305) begin n_err++; $display("FAIL ecall_raddr: got %h want 305", o_raddr); end
    n_vec++; if (o_req_cnt !== 4 || o_req_unstable) begin n_err++; $display("FAIL ecall_hold: got %0d cycles unstable=%b want 4/0", o_req_cnt, o_req_unstable); end
    n_vec++; if (o_ecall !== 1'b1 || o_wen !== 1'b0 || o_pc !== 32'h8000_0040) begin
      n_err++; $display("FAIL ecall_req: got ecall=%b wen=%b pc=%h want 1/0/80000040", o_ecall, o_wen, o_pc); end
    n_vec++; if (o_redir !== 1'b1 || o_redir_pc !== 32'h8000_0200 || o_rdwen !== 1'b0) begin
      n_err++; $display("FAIL ecall_resp: got redir=%b pc=%h rdwen=%b want 1/80000200/0", o_redir, o_redir_pc, o_rdwen); end
    n_vec++; if (o_lat !== 6) begin n_err++; $display("FAIL ecall_latency: got %0d want 6", o_lat); end
  endtask

  task automatic test_mret();
    csr_mem[12'h341] = 32'h8000_0044;
    run(3'd4, 12'h000, 32'h0, 1'b1, 5'd0, 32'h8000_0100, 0, 0);
    n_vec++; if (o_raddr !== 12'h341) begin n_err++; $display("FAIL mret_raddr: got %h want 341", o_raddr); end
    n_vec++; if (o_req_cnt !== 0 || o_lat !== 1) begin n_err++; $display("FAIL mret_timing: got req=%0d lat=%0d want 0/1", o_req_cnt, o_lat); end
    n_vec++; if (o_redir !== 1'b1 || o_redir_pc !== 32'h8000_0044 || o_rdwen !== 1'b0) begin
      n_err++; $display("FAIL mret_resp: got redir=%b pc=%h rdwen=%b want 1/80000044/0", o_redir, o_redir_pc, o_rdwen); end
  endtask

  task automatic test_backpressure_reset();
    csr_mem[12'h340] = 32'hCAFE_0001;
    run(3'd0, 12'h340, 32'h1234_5678, 1'b0, 5'd9, 32'h8000_0200, 0, 4);
    n_vec++; if (o_resp_unstable || o_lat !== 3) begin n_err++; $display("FAIL bp_hold: got unstable=%b lat=%0d want 0/3", o_resp_unstable, o_lat); end
    n_vec++; if (o_rdwdata !== 32'hCAFE_0001 || o_rdaddr !== 5'd9) begin n_err++; $display("FAIL bp_rd: got %h/%0d want cafe0001/9", o_rdwdata, o_rdaddr); end
    n_vec++; if (o_in_ready_after !== 1'b1) begin n_err++; $display("FAIL bp_idle: got in_ready=%b want 1", o_in_ready_after); end
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_csr_addr = 12'h340; bus.in_src = 32'h55;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_csr_addr = 12'h0; bus.in_src = 32'h0;
    bus.in_src_zero = 1'b0; bus.in_rd = 5'd0; bus.in_pc = 32'h0;
    @(negedge clk); @(negedge clk);
    n_vec++; if (bus.csr_valid !== 1'b1) begin n_err++; $display("FAIL abort_pre: got csr_valid=%b want 1", bus.csr_valid); end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1 || {bus.csr_raddr, bus.csr_valid, bus.csr_waddr, bus.csr_wdata, bus.csr_wen,
        bus.csr_is_ecall, bus.csr_pc, bus.out_valid, bus.rd_wen, bus.rd_addr, bus.rd_wdata,
        bus.redirect_valid, bus.redirect_pc, bus.illegal} !== '0) begin
      n_err++; $display("FAIL abort_reset: got in_ready=%b csr_valid=%b wdata=%h want 1/0/0",
                        bus.in_ready, bus.csr_valid, bus.csr_wdata);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.csr_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_after: got valid=%b out=%b ready=%b want 0/0/1", bus.csr_valid, bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_ro();
    csr_mem[12'hF11] = 32'h7973_7978;
    run(3'd0, 12'hF11, 32'hDEAD_BEEF, 1'b0, 5'd7, 32'h8000_0300, 0, 0);
    n_vec++; if (o_req_cnt !== 1) begin n_err++; $display("FAIL ro_handshake: got %0d want 1", o_req_cnt); end
`ifdef CSR_WB_RO_CHECK_EN
    n_vec++; if (o_wen !== 1'b0 || o_ill !== 1'b1) begin n_err++; $display("FAIL ro_check: got wen=%b ill=%b want 0/1", o_wen, o_ill); end
`else
    n_vec++; if (o_wen !== 1'b1 || o_ill !== 1'b0) begin n_err++; $display("FAIL ro_nocheck: got wen=%b ill=%b want 1/0", o_wen, o_ill); end
`endif
    n_vec++; if (o_rdwen !== 1'b1 || o_rdwdata !== 32'h7973_7978) begin n_err++; $display("FAIL ro_rd: got %b/%h want 1/79737978", o_rdwen, o_rdwdata); end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [11:0] addr; logic [31:0] src, pc; logic sz; logic [4:0] rd;
    int rdy, odl;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: addr = 12'h300;  1: addr = 12'h305;  2: addr = 12'h341;
        3: addr = 12'hF11;  4: addr = 12'hF12;  default: addr = 12'($urandom);
      endcase
      sz  = ($urandom_range(0, 3) == 0);
      src = sz ? 32'h0 : $urandom;
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      pc  = {$urandom, 2'b00} >> 2 << 2;
      rdy = $urandom_range(0, 3);
      odl = $urandom_range(0, 3);
      model(op, addr, src, sz, rd, rdy);
      run(op, addr, src, sz, rd, pc, rdy, odl);
      n_vec++; if (o_timeout) begin n_err++; $display("FAIL rnd%0d timeout: got timeout want completion op %0d", i, op); end
      n_vec++; if (o_in_ready !== 1'b1 || o_raddr !== e_raddr) begin n_err++; $display("FAIL rnd%0d accept: got ready=%b raddr=%h want 1/%h", i, o_in_ready, o_raddr, e_raddr); end
      n_vec++; if (o_req_cnt !== e_reqcnt || o_req_unstable) begin n_err++; $display("FAIL rnd%0d req_cycles: got %0d unstable=%b want %0d", i, o_req_cnt, o_req_unstable, e_reqcnt); end
      n_vec++; if (o_lat !== e_lat) begin n_err++; $display("FAIL rnd%0d latency: got %0d want %0d", i, o_lat, e_lat); end
      if (e_req) begin
        n_vec++; if (o_wen !== e_wen) begin n_err++; $display("FAIL rnd%0d wen: got %b want %b", i, o_wen, e_wen); end
        n_vec++; if (o_ecall !== (op == 3'd3)) begin n_err++; $display("FAIL rnd%0d is_ecall: got %b want %b", i, o_ecall, op == 3'd3); end
        if (op == 3'd3) begin
          n_vec++; if (o_pc !== pc) begin n_err++; $display("FAIL rnd%0d csr_pc: got %h want %h", i, o_pc, pc); end
        end else begin
          n_vec++; if (o_waddr !== addr || o_wdata !== e_wdata) begin n_err++; $display("FAIL rnd%0d wr: got %h/%h want %h/%h", i, o_waddr, o_wdata, addr, e_wdata); end
        end
      end
      n_vec++; if (o_rdwen !== e_rdwen || o_redir !== e_redir || o_ill !== e_ill || o_resp_unstable) begin
        n_err++; $display("FAIL rnd%0d resp_flags: got rdwen=%b redir=%b ill=%b uns=%b want %b/%b/%b/0",
                          i, o_rdwen, o_redir, o_ill, o_resp_unstable, e_rdwen, e_redir, e_ill); end
      if (e_rdwen) begin
        n_vec++; if (o_rdaddr !== rd || o_rdwdata !== e_old) begin n_err++; $display("FAIL rnd%0d rd: got %0d/%h want %0d/%h", i, o_rdaddr, o_rdwdata, rd, e_old); end
      end
      if (e_redir) begin
        n_vec++; if (o_redir_pc !== e_old) begin n_err++; $display("FAIL rnd%0d redirect_pc: got %h want %h", i, o_redir_pc, e_old); end
      end
      n_vec++; if (o_in_ready_after !== 1'b1) begin n_err++; $display("FAIL rnd%0d idle: got in_ready=%b want 1", i, o_in_ready_after); end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    clk = 1'b0; rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_csr_addr = 12'h0; bus.in_src = 32'h0;
    bus.in_src_zero = 1'b0; bus.in_rd = 5'd0; bus.in_pc = 32'h0;
    bus.csr_ready = 1'b0; bus.out_ready = 1'b0;
    for (int i = 0; i < 4096; i++) csr_mem[i] = $urandom;
    test_reset();
    test_csrrw();
    test_csrrs();
    test_ecall();
    test_mret();
    test_backpressure_reset();
    test_ro();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
